// File: rtl/i8080_rx_capture_pkg.sv
// Shared types and constants for the i8080 receive/capture slice.
package i8080_pkg;

  localparam int BUS_W = 16;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CASET = 2'd1,
    ST_PASET = 2'd2,
    ST_RAMWR = 2'd3
  } state_t;

  // Counter increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/i8080_rx_capture_if.sv
// i8080 (DBI) parallel write bus as seen by the host (master) and the receiver (slave).
interface i8080_rx_capture_if;
  import i8080_pkg::*;

  logic             I80_CS_N;
  logic             I80_WR_N;
  logic             I80_RS;
  logic [BUS_W-1:0] I80_D;

  modport master (output I80_CS_N, output I80_WR_N, output I80_RS, output I80_D);
  modport slave  (input  I80_CS_N, input  I80_WR_N, input  I80_RS, input  I80_D);

endinterface

// File: rtl/i8080_bus_sync.sv
// Synchroniser chain for the asynchronous i8080 pins plus WR_N rising-edge detect.
module i8080_bus_sync
  import i8080_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cs_n,
  input  logic             wr_n,
  input  logic             rs,
  input  logic [BUS_W-1:0] d,
  output logic             wr_evt,
  output logic             rs_s,
  output logic [BUS_W-1:0] d_s,
  output logic             cs_s
);

  logic [SYNC_STAGES-1:0] cs_q;
  logic [SYNC_STAGES-1:0] wr_q;
  logic [SYNC_STAGES-1:0] rs_q;
  logic [BUS_W-1:0]       d_q [SYNC_STAGES];
  logic                   wr_prev;

  // Shift every pin through the flop chain; reset parks the bus at its idle levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_q    <= '1;
      wr_q    <= '1;
      rs_q    <= '0;
      wr_prev <= 1'b1;
      for (int i = 0; i < SYNC_STAGES; i++) d_q[i] <= '0;
    end else begin
      cs_q    <= {cs_q[SYNC_STAGES-2:0], cs_n};
      wr_q    <= {wr_q[SYNC_STAGES-2:0], wr_n};
      rs_q    <= {rs_q[SYNC_STAGES-2:0], rs};
      wr_prev <= wr_q[SYNC_STAGES-1];
      d_q[0]  <= d;
      for (int i = 1; i < SYNC_STAGES; i++) d_q[i] <= d_q[i-1];
    end
  end

  // Synchronised views; wr_evt is the bare WR_N low-to-high edge, cs qualification is left to the caller.
  always_comb begin
    cs_s   = cs_q[SYNC_STAGES-1];
    rs_s   = rs_q[SYNC_STAGES-1];
    d_s    = d_q[SYNC_STAGES-1];
    wr_evt = ~wr_prev & wr_q[SYNC_STAGES-1];
  end

endmodule

// File: rtl/i8080_rx_capture.sv
// i8080 write-bus receiver: decodes CASET/PASET/RAMWR, tracks the write cursor, pushes RGB565 pixels.
//
//  state    | meaning
//  ST_IDLE  | no active command, data writes ignored
//  ST_CASET | collecting XS/XE bytes, P selects the byte
//  ST_PASET | collecting YS/YE bytes, P selects the byte
//  ST_RAMWR | data writes are pixels at the cursor
module i8080_rx_capture
  import i8080_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter int         H_RES       = 800,
  parameter int         V_RES       = 480,
  parameter logic [7:0] CMD_CASET   = i8080_pkg::CMD_CASET,
  parameter logic [7:0] CMD_PASET   = i8080_pkg::CMD_PASET,
  parameter logic [7:0] CMD_RAMWR   = i8080_pkg::CMD_RAMWR
) (
  input  logic                CLK,
  input  logic                RST,
  i8080_rx_capture_if.slave   i80,
  output logic                FIFO_WE,
  output logic [BUS_W-1:0]    FIFO_WDATA,
  input  logic                FIFO_FULL,
  output logic                FRAME_START,
  output logic [15:0]         OVF_CNT,
  output logic [15:0]         CUR_X,
  output logic [15:0]         CUR_Y
);

  localparam logic [15:0] XE_RST = 16'(H_RES - 1);
  localparam logic [15:0] YE_RST = 16'(V_RES - 1);

  logic             wr_edge, rs_s, cs_s, evt;
  logic [BUS_W-1:0] d_s;

  i8080_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (CLK),
    .rst    (RST),
    .cs_n   (i80.I80_CS_N),
    .wr_n   (i80.I80_WR_N),
    .rs     (i80.I80_RS),
    .d      (i80.I80_D),
    .wr_evt (wr_edge),
    .rs_s   (rs_s),
    .d_s    (d_s),
    .cs_s   (cs_s)
  );

  assign evt = wr_edge & ~cs_s;

  state_t      state, state_nxt;
  logic [1:0]  p, p_nxt;
  logic [15:0] xs, xe, ys, ye;
  logic [15:0] xs_nxt, xe_nxt, ys_nxt, ye_nxt;
  logic [15:0] cx_nxt, cy_nxt, ovf_nxt;
  logic [15:0] wdata_nxt;
  logic        we_nxt, fs_nxt;

  // State, window, cursor and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_IDLE;
      p           <= 2'd0;
      xs          <= 16'd0;
      xe          <= XE_RST;
      ys          <= 16'd0;
      ye          <= YE_RST;
      CUR_X       <= 16'd0;
      CUR_Y       <= 16'd0;
      OVF_CNT     <= 16'd0;
      FIFO_WE     <= 1'b0;
      FIFO_WDATA  <= '0;
      FRAME_START <= 1'b0;
    end else begin
      state       <= state_nxt;
      p           <= p_nxt;
      xs          <= xs_nxt;
      xe          <= xe_nxt;
      ys          <= ys_nxt;
      ye          <= ye_nxt;
      CUR_X       <= cx_nxt;
      CUR_Y       <= cy_nxt;
      OVF_CNT     <= ovf_nxt;
      FIFO_WE     <= we_nxt;
      FIFO_WDATA  <= wdata_nxt;
      FRAME_START <= fs_nxt;
    end
  end

  // Command decode, parameter capture and pixel/cursor handling on each write event.
  always_comb begin
    state_nxt = state;
    p_nxt     = p;
    xs_nxt    = xs;
    xe_nxt    = xe;
    ys_nxt    = ys;
    ye_nxt    = ye;
    cx_nxt    = CUR_X;
    cy_nxt    = CUR_Y;
    ovf_nxt   = OVF_CNT;
    we_nxt    = 1'b0;
    wdata_nxt = FIFO_WDATA;
    fs_nxt    = 1'b0;

    if (evt) begin
      if (!rs_s) begin
        if (d_s[7:0] == CMD_CASET) begin
          state_nxt = ST_CASET;
          p_nxt     = 2'd0;
        end else if (d_s[7:0] == CMD_PASET) begin
          state_nxt = ST_PASET;
          p_nxt     = 2'd0;
        end else if (d_s[7:0] == CMD_RAMWR) begin
          state_nxt = ST_RAMWR;
          cx_nxt    = xs;
          cy_nxt    = ys;
          fs_nxt    = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end else begin
        case (state)
          ST_CASET, ST_PASET: begin
            case ({state == ST_PASET, p})
              3'b000: xs_nxt[15:8] = d_s[7:0];
              3'b001: xs_nxt[7:0]  = d_s[7:0];
              3'b010: xe_nxt[15:8] = d_s[7:0];
              3'b011: xe_nxt[7:0]  = d_s[7:0];
              3'b100: ys_nxt[15:8] = d_s[7:0];
              3'b101: ys_nxt[7:0]  = d_s[7:0];
              3'b110: ye_nxt[15:8] = d_s[7:0];
              default: ye_nxt[7:0] = d_s[7:0];
            endcase
            p_nxt = p + 2'd1;
            if (p == 2'd3) state_nxt = ST_IDLE;
          end
          ST_RAMWR: begin
            if (!FIFO_FULL) begin
              we_nxt    = 1'b1;
              wdata_nxt = d_s;
            end else begin
              ovf_nxt = sat_inc16(OVF_CNT);
            end
            if (CUR_X == xe) begin
              cx_nxt = xs;
              cy_nxt = (CUR_Y == ye) ? ys : CUR_Y + 16'd1;
            end else begin
              cx_nxt = CUR_X + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i8080_rx_capture.sv
// Randomised scoreboard bench for i8080_rx_capture against a behavioural model.
module tb_i8080_rx_capture;
  import i8080_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        FIFO_FULL = 1'b0;
  logic        FIFO_WE, FRAME_START, we3, fs3;
  logic [15:0] FIFO_WDATA, OVF_CNT, CUR_X, CUR_Y;
  logic [15:0] wd3, ovf3, cx3, cy3;

  i8080_rx_capture_if bus ();

  i8080_rx_capture #(.SYNC_STAGES(2)) dut (
    .CLK(CLK), .RST(RST), .i80(bus.slave),
    .FIFO_WE(FIFO_WE), .FIFO_WDATA(FIFO_WDATA), .FIFO_FULL(FIFO_FULL),
    .FRAME_START(FRAME_START), .OVF_CNT(OVF_CNT), .CUR_X(CUR_X), .CUR_Y(CUR_Y)
  );

  i8080_rx_capture #(.SYNC_STAGES(3)) dut3 (
    .CLK(CLK), .RST(RST), .i80(bus.slave),
    .FIFO_WE(we3), .FIFO_WDATA(wd3), .FIFO_FULL(FIFO_FULL),
    .FRAME_START(fs3), .OVF_CNT(ovf3), .CUR_X(cx3), .CUR_Y(cy3)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  int we_cnt = 0;
  int fs_cnt = 0;
  int lat2, lat3;
  logic we_prev = 1'b0;

  logic [15:0] exp_q[$];

  // reference model
  int          m_mode;   // 0 idle, 1 column params, 2 page params, 3 pixels
  int          m_idx;
  logic [15:0] m_xs, m_xe, m_ys, m_ye, m_x, m_y, m_ovf;
  int          m_fs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_idx = 0;
    m_xs = 0; m_xe = 16'd799; m_ys = 0; m_ye = 16'd479;
    m_x = 0; m_y = 0; m_ovf = 0;
  endtask

  task automatic model_evt(input logic rs_v, input logic [15:0] d_v, input logic full_v);
    logic [31:0] w;
    if (!rs_v) begin
      case (d_v[7:0])
        8'h2A: begin m_mode = 1; m_idx = 0; end
        8'h2B: begin m_mode = 2; m_idx = 0; end
        8'h2C: begin m_mode = 3; m_x = m_xs; m_y = m_ys; m_fs++; end
        default: m_mode = 0;
      endcase
    end else if (m_mode == 1 || m_mode == 2) begin
      w = (m_mode == 1) ? {m_xs, m_xe} : {m_ys, m_ye};
      w[31 - 8*m_idx -: 8] = d_v[7:0];
      if (m_mode == 1) {m_xs, m_xe} = w; else {m_ys, m_ye} = w;
      m_idx++;
      if (m_idx == 4) m_mode = 0;
    end else if (m_mode == 3) begin
      if (!full_v) exp_q.push_back(d_v);
      else if (m_ovf != 16'hFFFF) m_ovf++;
      if (m_x == m_xe) begin
        m_x = m_xs;
        m_y = (m_y == m_ye) ? m_ys : 16'((int'(m_y) + 1) % 65536);
      end else begin
        m_x = 16'((int'(m_x) + 1) % 65536);
      end
    end
  endtask

  // one host write cycle; cs_v=1 strobes WR_N with the chip deselected
  task automatic bus_wr(input logic rs_v, input logic [15:0] d_v, input logic full_v,
                        input logic cs_v, input bit measure);
    @(negedge CLK);
    bus.I80_CS_N = cs_v; bus.I80_RS = rs_v; bus.I80_D = d_v; FIFO_FULL = full_v;
    @(negedge CLK);
    bus.I80_WR_N = 1'b0;
    repeat (5) @(negedge CLK);
    if (!cs_v) model_evt(rs_v, d_v, full_v);
    bus.I80_WR_N = 1'b1;
    lat2 = -1; lat3 = -1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge CLK); #1;
      if (FIFO_WE && lat2 < 0) lat2 = k;
      if (we3 && lat3 < 0) lat3 = k;
    end
    @(negedge CLK);
    bus.I80_CS_N = 1'b1;
    chk("cur_x", {16'd0, CUR_X}, {16'd0, m_x});
    chk("cur_y", {16'd0, CUR_Y}, {16'd0, m_y});
    chk("ovf_cnt", {16'd0, OVF_CNT}, {16'd0, m_ovf});
    if (measure) begin
      chk("latency_sync2", lat2, 3);
      chk("latency_sync3", lat3, 4);
    end
  endtask

  task automatic cmd(input logic [7:0] op);
    bus_wr(1'b0, {8'($urandom), op}, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic dat(input logic [15:0] v, input logic full_v);
    bus_wr(1'b1, v, full_v, 1'b0, 1'b0);
  endtask

  // scoreboard monitor: pop an expected pixel on every FIFO write
  always @(posedge CLK) begin
    #1;
    if (FRAME_START) fs_cnt++;
    if (FIFO_WE) begin
      we_cnt++;
      chk("we_not_back_to_back", {31'd0, we_prev}, 32'd0);
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_we: got data %0h expected no write at %0t", FIFO_WDATA, $time);
      end else begin
        chk("fifo_wdata", {16'd0, FIFO_WDATA}, {16'd0, exp_q.pop_front()});
      end
    end
    we_prev = FIFO_WE;
  end

  int we_base, fs_base;
  logic [15:0] v;

  initial begin
    bus.I80_CS_N = 1'b1; bus.I80_WR_N = 1'b1; bus.I80_RS = 1'b0; bus.I80_D = '0;
    model_reset(); m_fs = 0;
    repeat (4) @(negedge CLK);
    chk("rst_fifo_we", {31'd0, FIFO_WE}, 0);
    chk("rst_fifo_wdata", {16'd0, FIFO_WDATA}, 0);
    chk("rst_frame_start", {31'd0, FRAME_START}, 0);
    chk("rst_ovf", {16'd0, OVF_CNT}, 0);
    chk("rst_cur_x", {16'd0, CUR_X}, 0);
    chk("rst_cur_y", {16'd0, CUR_Y}, 0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // basic RAMWR with three primaries, latency measured on the first pixel
    fs_base = fs_cnt; we_base = we_cnt;
    cmd(8'h2C);
    bus_wr(1'b1, 16'hF800, 1'b0, 1'b0, 1'b1);
    dat(16'h07E0, 1'b0);
    dat(16'h001F, 1'b0);
    chk("t1_frame_start", fs_cnt - fs_base, 1);
    chk("t1_we_count", we_cnt - we_base, 3);
    chk("t1_cur_x", {16'd0, CUR_X}, 3);
    chk("t1_cur_y", {16'd0, CUR_Y}, 0);

    // 3x2 window with wrap back to the origin
    cmd(8'h2A); dat(16'h0000, 0); dat(16'h000A, 0); dat(16'h0000, 0); dat(16'h000C, 0);
    cmd(8'h2B); dat(16'h0000, 0); dat(16'h0005, 0); dat(16'h0000, 0); dat(16'h0006, 0);
    cmd(8'h2C);
    chk("t2_start", {CUR_X, CUR_Y}, {16'd10, 16'd5});
    for (int i = 0; i < 6; i++) dat(16'($urandom), 0);
    chk("t2_wrap", {CUR_X, CUR_Y}, {16'd10, 16'd5});

    // FIFO full on 4 of 10 pixels
    we_base = we_cnt;
    for (int i = 0; i < 10; i++) dat(16'($urandom), (i == 2 || i == 3 || i == 6 || i == 9));
    chk("t3_we_count", we_cnt - we_base, 6);
    chk("t3_ovf", {16'd0, OVF_CNT}, 4);

    // strobes with CS_N high are invisible; data in idle is ignored
    we_base = we_cnt;
    for (int i = 0; i < 3; i++) bus_wr(1'b1, 16'($urandom), 1'b0, 1'b1, 1'b0);
    bus_wr(1'b0, 16'h0011, 1'b0, 1'b1, 1'b0);
    dat(16'h1234, 0);
    cmd(8'h00);
    dat(16'hBEEF, 0);
    dat(16'hCAFE, 0);
    chk("t4_we_count", we_cnt - we_base, 1);

    // reset in the middle of CASET parameter 2
    cmd(8'h2A); dat(16'h0000, 0); dat(16'h0007, 0);
    @(negedge CLK);
    bus.I80_CS_N = 1'b0; bus.I80_RS = 1'b1; bus.I80_D = 16'h0003;
    @(negedge CLK); bus.I80_WR_N = 1'b0;
    repeat (3) @(negedge CLK); RST = 1'b1;
    repeat (3) @(negedge CLK); bus.I80_WR_N = 1'b1;
    repeat (4) @(negedge CLK); bus.I80_CS_N = 1'b1; RST = 1'b0;
    model_reset();
    @(negedge CLK);
    cmd(8'h2C);
    chk("t5_origin", {CUR_X, CUR_Y}, 32'd0);
    dat(16'h5A5A, 0);
    chk("t5_cursor", {CUR_X, CUR_Y}, {16'd1, 16'd0});
    chk("t5_ovf", {16'd0, OVF_CNT}, 0);

    // randomised traffic
    for (int n = 0; n < 60; n++) begin
      int r;
      r = $urandom_range(0, 11);
      if (r == 0 || r == 1) begin
        cmd(r == 0 ? 8'h2A : 8'h2B);
        v = 16'($urandom_range(0, 12));
        dat({8'($urandom), 8'h00}, 0);
        dat({8'($urandom), v[7:0]}, 0);
        dat({8'($urandom), 8'h00}, 0);
        dat({8'($urandom), 8'(v + 16'($urandom_range(0, 3)))}, 0);
      end else if (r == 2) begin
        cmd(8'h2C);
      end else if (r == 3) begin
        cmd(8'($urandom));
      end else if (r == 4) begin
        bus_wr(1'($urandom), 16'($urandom), 1'b0, 1'b1, 1'b0);
      end else begin
        dat(16'($urandom), ($urandom_range(0, 3) == 0));
      end
    end

    repeat (10) @(negedge CLK);
    chk("frame_start_total", fs_cnt, m_fs);
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i8080_rx_capture.md
Name: i8080_rx_capture

Overview:
- Upstream stage of the RGB panel scan-out.
- Receives an MCU i8080 (8080-style DBI) parallel write bus and synchronises it into the CLK domain.
- Decodes the column, page and memory-write commands, tracks the write cursor, and pushes RGB565 pixels into the pixel FIFO.
- The panel timing stage drains that FIFO.

Parameters:
- SYNC_STAGES, 2, synchroniser depth on the i8080 control and data pins (min 2).
- H_RES, 800, reset value of column end + 1.
- V_RES, 480, reset value of page end + 1.
- CMD_CASET, 8'h2A, column address set opcode.
- CMD_PASET, 8'h2B, page address set opcode.
- CMD_RAMWR, 8'h2C, memory write opcode.

Ports:
- CLK  in  1  system clock; all logic on its rising edge.
- RST  in  1  synchronous, active-high reset.
- I80_CS_N  in  1  chip select, active low, asynchronous to CLK.
- I80_WR_N  in  1  write strobe; data is latched on its rising edge.
- I80_RS  in  1  0 = command, 1 = data.
- I80_D  in  16  bus data; commands use [7:0].
- FIFO_WE  out  1  one-cycle pixel write enable.
- FIFO_WDATA  out  16  RGB565 pixel.
- FIFO_FULL  in  1  FIFO cannot accept a write this cycle.
- FRAME_START  out  1  one-cycle pulse on each accepted RAMWR command.
- OVF_CNT  out  16  count of pixels dropped because the FIFO was full; saturates at 16'hFFFF.
- CUR_X  out  16  current write column.
- CUR_Y  out  16  current write page.

Behaviour:
- Synchronising: CS_N, WR_N, RS and D each pass through SYNC_STAGES flops.
- Write event: the synchronised WR_N was 0 last cycle and is 1 now, while the synchronised CS_N is 0.
  - The event uses the synchronised RS and D from that same cycle.
  - Host contract: WR_N low and high time >= SYNC_STAGES+1 CLK periods each, and D/RS stable over that window.
- Latency: FIFO_WE/FIFO_WDATA are registered. FIFO_WE asserts exactly SYNC_STAGES+1 CLK edges after the first edge that samples I80_WR_N high.
- Reset (RST=1 at a CLK edge):
  - State goes to ST_IDLE.
  - FIFO_WE=0, FIFO_WDATA=0, FRAME_START=0, OVF_CNT=0, CUR_X=0, CUR_Y=0.
  - Window: XS=0, XE=H_RES-1, YS=0, YE=V_RES-1.
  - Synchronisers are set to idle levels (CS_N=1, WR_N=1).
  - A transfer in flight when reset asserts is discarded.
- States: ST_IDLE, ST_CASET, ST_PASET, ST_RAMWR. A 2-bit parameter index P is used in CASET/PASET.
- Command event (RS=0), accepted in any state:
  - CMD_CASET: go to ST_CASET, P=0.
  - CMD_PASET: go to ST_PASET, P=0.
  - CMD_RAMWR: go to ST_RAMWR, set CUR_X=XS, CUR_Y=YS, pulse FRAME_START.
  - Any other opcode: go to ST_IDLE.
  - D[15:8] is ignored.
- Data event in ST_CASET:
  - P=0 writes XS[15:8], P=1 XS[7:0], P=2 XE[15:8], P=3 XE[7:0]; each writes D[7:0].
  - P increments after each write; after P=3 go to ST_IDLE.
- Data event in ST_PASET: same sequence on YS/YE.
- Data event in ST_RAMWR:
  - If FIFO_FULL=0: FIFO_WE=1 for one cycle, FIFO_WDATA=D.
  - If FIFO_FULL=1: no write, and OVF_CNT increments (saturating).
  - The cursor advances in both cases. If CUR_X==XE, CUR_X=XS and CUR_Y=(CUR_Y==YE)?YS:CUR_Y+1; otherwise CUR_X+1.
  - The module stays in ST_RAMWR until a command event arrives.
- Data event in ST_IDLE: ignored.
- CS_N deasserting does not change state; RAMWR continues after reselect.
- FIFO_FULL is sampled in the same cycle as the event; there is no buffering, so a drop is final.
- XS>XE or YS>YE: the window is not validated. Wrap occurs only on equality; otherwise the cursor increments through 16'hFFFF to 0.
- FIFO_WE is never asserted on two consecutive cycles (follows from the strobe width contract).

Decomposition:
- Package i8080_pkg: state enum, CMD_* opcodes, bus width constant 16.
- One sub-module, i8080_bus_sync: parameterised flop chain plus WR rising-edge detector. Outputs: wr_evt, rs_s, d_s, cs_s.

Test Plan:
- Reset, then RAMWR followed by 3 data writes 16'hF800, 16'h07E0, 16'h001F with FIFO not full -> FRAME_START pulses once; FIFO receives exactly those 3 words in order; CUR_X=3, CUR_Y=0.
- CASET params 00,0A,00,0C; PASET 00,05,00,06; RAMWR; 6 pixels -> CUR_X/CUR_Y sequence (10,5)(11,5)(12,5)(10,6)(11,6)(12,6), then back to (10,5).
- FIFO_FULL held high during 4 of 10 RAMWR pixels -> 6 FIFO_WE pulses; OVF_CNT=4; cursor advanced 10.
- WR_N pulses while CS_N=1 -> no FIFO_WE and no state change. Data with RS=1 in ST_IDLE -> ignored.
- Latency check with SYNC_STAGES=2 -> FIFO_WE rises on the 3rd CLK edge after WR_N is sampled high. With SYNC_STAGES=3 -> 4th edge.
- RST asserted midway through CASET param 2, then RAMWR and one pixel -> cursor (0,0) from default window; OVF_CNT=0.
